quad_step_decoder: RTL
======================

Name: quad_step_decoder

Overview:
- Receive-side decoder for a two-phase quadrature (Gray-coded) step interface, such as a rotary encoder or a stepper-driver feedback link.
- Synchronises the asynchronous A/B phase inputs and decodes each legal phase transition into an up or down step.
- Keeps a wrap-around position count and flags illegal double-phase transitions.
- Sits between the off-chip phase pins and the up/down counter consumers in the design.

Parameters:
- WIDTH, 4, width of the position count.
- SYNC_STAGES, 2, flip-flop stages in each input synchroniser; must be 2 or more.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- en  input  1  decode enable; 0 freezes count, step, wrap and err.
- clear  input  1  synchronous clear of count and err.
- a_in  input  1  phase A, asynchronous to clk.
- b_in  input  1  phase B, asynchronous to clk.
- count  output  WIDTH  current position.
- dir  output  1  direction of the last accepted step; 0 = up, 1 = down.
- step  output  1  one-cycle pulse per accepted step.
- wrap  output  1  one-cycle pulse when count wraps in either direction.
- err  output  1  sticky flag for an illegal transition.

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, dir=0, step=0, wrap=0, err=0.
  - Synchroniser flops, previous-phase register prev[1:0] and the prime counter are all cleared.
- Synchroniser:
  - a_in and b_in each pass through SYNC_STAGES flops.
  - The last stage gives cur = {a_s, b_s}.
- Priming after reset release:
  - A prime counter counts SYNC_STAGES+1 rising edges.
  - Until it saturates, prev <= cur every cycle and no decode occurs: no step, no err.
  - This prevents a false err when the phases are not 00 at reset release.
- Decode, once primed, evaluated every cycle on (prev, cur):
  - up (+1, dir<=0): 00->01, 01->11, 11->10, 10->00.
  - down (-1, dir<=1): 00->10, 10->11, 11->01, 01->00.
  - prev == cur: no action.
  - Illegal transition (00<->11 or 01<->10): err<=1, count unchanged, no step.
  - prev <= cur every cycle regardless of en, so no transition is replayed when en returns to 1.
- Latency:
  - A phase change stable before rising edge k appears in cur after edge k+SYNC_STAGES-1.
  - count, dir and step update at edge k+SYNC_STAGES. With SYNC_STAGES=2 this is the 3rd edge.
- Arithmetic:
  - count is modulo 2^WIDTH.
  - Up from 2^WIDTH-1 gives 0 with wrap=1.
  - Down from 0 gives 2^WIDTH-1 with wrap=1.
  - wrap is 1 only in a cycle where step is 1.
- en=0:
  - No change to count, dir or err.
  - step and wrap stay 0.
  - Synchroniser and prev keep tracking the inputs.
- clear=1 (sync):
  - count<=0 and err<=0.
  - Takes priority over a step in the same cycle: that step is discarded, step=0, wrap=0, dir unchanged.
  - An illegal transition in the same cycle does not set err.
  - clear acts even when en=0.
- Sticky err: stays 1 until clear or reset; decoding of legal steps continues while err=1.
- Reset mid-operation:
  - All state is cleared immediately and priming restarts.
  - Steps in flight are lost.
- All outputs are registered; there are no combinational paths from input to output.

Test Plan:
1. Reset with a_in=b_in=0, release, then forward sequence 01,11,10,00, each phase held 4 cycles -> count 1,2,3,4; dir=0; exactly 4 step pulses, each on the 3rd edge after its input change; err=0.
2. From count=4, reverse sequence of 6 transitions -> count 3,2,1,0,15,14; dir=1; single wrap pulse on the 0->15 step.
3. Drive count to 15 with up steps, then one more up -> count=0, wrap=1 and step=1 in the same cycle, dir=0.
4. Phases at 00, jump both to 11 -> err=1, count unchanged, no step. Further legal up steps still count. Pulse clear -> count=0, err=0.
5. en=0 while 3 forward transitions are applied -> count, dir and step unchanged. Set en=1, apply 1 forward transition -> count advances by exactly 1.
6. Hold a_in=b_in=1, assert reset mid-sequence (count=7), release -> count=0, err stays 0 through priming. Then transition 11->10 -> count=1, dir=0. Also assert clear in the same cycle as a step -> count=0, step=0.

Source files
------------

// File: rtl/quad_step_decoder_if.sv
// Signal bundle between the quadrature phase pins/control and the step decoder.
// The master drives phases and control; the slave (the decoder) drives position and status.
interface quad_step_decoder_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             clear;
    logic             a_in;
    logic             b_in;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             wrap;
    logic             err;

    modport master (
        output en,
        output clear,
        output a_in,
        output b_in,
        input  count,
        input  dir,
        input  step,
        input  wrap,
        input  err
    );

    modport slave (
        input  en,
        input  clear,
        input  a_in,
        input  b_in,
        output count,
        output dir,
        output step,
        output wrap,
        output err
    );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature (Gray-coded A/B) step decoder: synchronises the phases, decodes legal
// transitions into up/down steps on a wrap-around count, and latches illegal jumps.
module quad_step_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2   // must be 2 or more
) (
    input  logic               clk,
    input  logic               reset,
    quad_step_decoder_if.slave bus
);

    localparam int                PW        = $clog2(SYNC_STAGES + 2);
    localparam logic [PW-1:0]     PRIME_MAX = PW'(SYNC_STAGES + 1);
    localparam logic [PW-1:0]     PRIME_ONE = PW'(1);
    localparam logic [WIDTH-1:0]  COUNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0]  COUNT_MAX = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        MOVE_NONE    = 2'd0,
        MOVE_UP      = 2'd1,
        MOVE_DOWN    = 2'd2,
        MOVE_ILLEGAL = 2'd3
    } move_e;

    // Gray-code transition table: one-bit changes are steps, two-bit changes are illegal.
    function automatic move_e decode_move(input logic [1:0] prev, input logic [1:0] cur);
        move_e m;
        m = MOVE_NONE;
        case ({prev, cur})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: m = MOVE_UP;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: m = MOVE_DOWN;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: m = MOVE_ILLEGAL;
            default:                            m = MOVE_NONE;
        endcase
        return m;
    endfunction

    logic [SYNC_STAGES-1:0] a_sync_q;
    logic [SYNC_STAGES-1:0] b_sync_q;
    logic [1:0]             prev_q;
    logic [PW-1:0]          prime_q;
    logic [PW-1:0]          prime_d;
    logic [WIDTH-1:0]       count_q;
    logic [WIDTH-1:0]       count_d;
    logic                   dir_q;
    logic                   dir_d;
    logic                   step_q;
    logic                   step_d;
    logic                   wrap_q;
    logic                   wrap_d;
    logic                   err_q;
    logic                   err_d;

    logic [1:0]             cur_s;
    logic                   primed_s;
    move_e                  move_s;

    assign cur_s    = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};
    assign primed_s = (prime_q == PRIME_MAX);
    assign move_s   = decode_move(prev_q, cur_s);

    // Next-state for position, direction, pulses and the sticky error flag.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        prime_d = primed_s ? prime_q : (prime_q + PRIME_ONE);
        if (bus.clear) begin
            // clear wins over any step or illegal transition decoded this cycle
            count_d = '0;
            err_d   = 1'b0;
        end else if (bus.en && primed_s) begin
            case (move_s)
                MOVE_UP: begin
                    count_d = count_q + COUNT_ONE;
                    dir_d   = 1'b0;
                    step_d  = 1'b1;
                    wrap_d  = (count_q == COUNT_MAX);
                end
                MOVE_DOWN: begin
                    count_d = count_q - COUNT_ONE;
                    dir_d   = 1'b1;
                    step_d  = 1'b1;
                    wrap_d  = (count_q == '0);
                end
                MOVE_ILLEGAL: begin
                    err_d = 1'b1;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // State registers; prev tracks cur every cycle so nothing is replayed after en returns.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_sync_q <= '0;
            b_sync_q <= '0;
            prev_q   <= 2'b00;
            prime_q  <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], bus.a_in};
            b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], bus.b_in};
            prev_q   <= cur_s;
            prime_q  <= prime_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = dir_q;
    assign bus.step  = step_q;
    assign bus.wrap  = wrap_q;
    assign bus.err   = err_q;

endmodule
